// File: rtl/button_conditioner_if.sv
// rtl/button_conditioner_if.sv - Raw button pins in, conditioned per-button level and event pulses out
interface button_conditioner_if #(
    parameter int NUM_BUTTONS = 2
);
    logic [NUM_BUTTONS-1:0] button;
    logic [NUM_BUTTONS-1:0] btn_level;
    logic [NUM_BUTTONS-1:0] btn_press;
    logic [NUM_BUTTONS-1:0] btn_release;
    logic [NUM_BUTTONS-1:0] btn_long;

    modport master (
        output button,
        input  btn_level,
        input  btn_press,
        input  btn_release,
        input  btn_long
    );

    modport slave (
        input  button,
        output btn_level,
        output btn_press,
        output btn_release,
        output btn_long
    );
endinterface

// File: rtl/button_conditioner.sv
// rtl/button_conditioner.sv - Per-button synchronizer, debounce FSM, hold counter and press/release/long-press pulses
module button_conditioner #(
    parameter int          NUM_BUTTONS       = 2,
    parameter int          DEBOUNCE_CYCLES   = 50000,
    parameter int unsigned LONG_PRESS_CYCLES = 50000000
) (
    input  logic                  clk,
    input  logic                  rst,
    button_conditioner_if.slave   bus
);
    localparam int                CNT_W    = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [31:0]       HOLD_MAX = 32'(LONG_PRESS_CYCLES);
    localparam logic [31:0]       HOLD_PRE = HOLD_MAX - 32'd1;

    typedef enum logic [1:0] {
        ST_RELEASED,
        ST_PRESS_PENDING,
        ST_PRESSED,
        ST_RELEASE_PENDING
    } state_t;

    // Pins idle high, so the synchronizer resets to "released" to avoid a false press.
    logic [NUM_BUTTONS-1:0] r_sync1;
    logic [NUM_BUTTONS-1:0] r_sync2;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync1 <= '1;
            r_sync2 <= '1;
        end else begin
            r_sync1 <= bus.button;
            r_sync2 <= r_sync1;
        end
    end

    logic [NUM_BUTTONS-1:0] w_sample;
    logic [NUM_BUTTONS-1:0] w_level;
    logic [NUM_BUTTONS-1:0] w_press;
    logic [NUM_BUTTONS-1:0] w_release;
    logic [NUM_BUTTONS-1:0] w_long;

    assign w_sample = r_sync2;

    for (genvar g = 0; g < NUM_BUTTONS; g++) begin : g_ch
        state_t           r_state;
        logic [CNT_W-1:0] r_cnt;
        logic [31:0]      r_hold;
        logic             r_level;
        logic             r_press;
        logic             r_release;
        logic             r_long;

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                r_state   <= ST_RELEASED;
                r_cnt     <= '0;
                r_hold    <= '0;
                r_level   <= 1'b0;
                r_press   <= 1'b0;
                r_release <= 1'b0;
                r_long    <= 1'b0;
            end else begin
                r_press   <= 1'b0;
                r_release <= 1'b0;
                r_long    <= 1'b0;

                // Hold time keeps running through RELEASE_PENDING; saturation stops a repeat long pulse.
                if (r_level && (r_hold != HOLD_MAX)) begin
                    r_hold <= r_hold + 32'd1;
                    if (r_hold == HOLD_PRE) begin
                        r_long <= 1'b1;
                    end
                end

                case (r_state)
                    ST_RELEASED: begin
                        if (!w_sample[g]) begin
                            r_state <= ST_PRESS_PENDING;
                            r_cnt   <= CNT_ONE;
                        end
                    end
                    ST_PRESS_PENDING: begin
                        if (w_sample[g]) begin
                            r_state <= ST_RELEASED;
                            r_cnt   <= '0;
                        end else if (r_cnt == CNT_LAST) begin
                            r_state <= ST_PRESSED;
                            r_cnt   <= '0;
                            r_level <= 1'b1;
                            r_press <= 1'b1;
                            r_hold  <= '0;
                        end else begin
                            r_cnt <= r_cnt + CNT_ONE;
                        end
                    end
                    ST_PRESSED: begin
                        if (w_sample[g]) begin
                            r_state <= ST_RELEASE_PENDING;
                            r_cnt   <= CNT_ONE;
                        end
                    end
                    ST_RELEASE_PENDING: begin
                        if (!w_sample[g]) begin
                            r_state <= ST_PRESSED;
                            r_cnt   <= '0;
                        end else if (r_cnt == CNT_LAST) begin
                            r_state   <= ST_RELEASED;
                            r_cnt     <= '0;
                            r_level   <= 1'b0;
                            r_release <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt + CNT_ONE;
                        end
                    end
                    default: begin
                        r_state <= ST_RELEASED;
                        r_cnt   <= '0;
                    end
                endcase
            end
        end

        assign w_level[g]   = r_level;
        assign w_press[g]   = r_press;
        assign w_release[g] = r_release;
        assign w_long[g]    = r_long;
    end

    assign bus.btn_level   = w_level;
    assign bus.btn_press   = w_press;
    assign bus.btn_release = w_release;
    assign bus.btn_long    = w_long;
endmodule

// File: doc/button_conditioner.md
# button_conditioner

Input-side conditioner for the board push-buttons. It takes the raw, active-low, asynchronous `button` pins and produces clean per-button outputs: a debounced active-high level, and single-cycle press, release and long-press event pulses. It sits between the pad inputs and the user logic that consumes button events, such as LED and counter control or operand stepping. That logic therefore no longer samples raw pins directly.

## Interface
- `NUM_BUTTONS`, default 2: number of independent button channels.
- `DEBOUNCE_CYCLES`, default 50000: consecutive stable samples required to accept a level change. Must be ≥ 2.
- `LONG_PRESS_CYCLES`, default 50000000: cycles of debounced hold before a long-press event. Must be ≥ 1, and must fit in 32 bits.
- `clk`, input, 1: the only clock. The block has one clock.
- `rst`, input, 1: reset, asynchronous and active-low. All state clears immediately on assertion.
- `button`, input, NUM_BUTTONS: raw pins, active low (0 = pressed), asynchronous to `clk`.
- `btn_level`, output, NUM_BUTTONS: debounced state, 1 = pressed.
- `btn_press`, output, NUM_BUTTONS: one-cycle pulse when a press is accepted.
- `btn_release`, output, NUM_BUTTONS: one-cycle pulse when a release is accepted.
- `btn_long`, output, NUM_BUTTONS: one-cycle pulse, at most once per press, when the hold time reaches LONG_PRESS_CYCLES.

## Operation
- Channels are fully independent. Each channel has the same logic and no shared state.
- **Synchronizer:** a 2-flop synchronizer per bit, reset value 1 (released). The FSM uses the second flop's output, `s2`, as its sample.
- **Debounce FSM per channel:** four states, RELEASED, PRESS_PENDING, PRESSED and RELEASE_PENDING. It has its own debounce counter of ceil(log2(DEBOUNCE_CYCLES)) bits.
  - RELEASED, `s2`=0 → PRESS_PENDING with cnt=1.
  - PRESS_PENDING, `s2`=0:
    - if cnt = DEBOUNCE_CYCLES−1 → PRESSED: `btn_level`←1, `btn_press` pulses, hold counter cleared;
    - otherwise cnt+1.
  - PRESS_PENDING, `s2`=1 → RELEASED with cnt=0. No event is produced.
  - PRESSED, `s2`=1 → RELEASE_PENDING with cnt=1.
  - RELEASE_PENDING, `s2`=1:
    - if cnt = DEBOUNCE_CYCLES−1 → RELEASED: `btn_level`←0, `btn_release` pulses;
    - otherwise cnt+1.
  - RELEASE_PENDING, `s2`=0 → PRESSED with cnt=0. No event is produced.
  - Net effect: a change is accepted only after DEBOUNCE_CYCLES consecutive samples agree. Any disagreeing sample restarts qualification.
- **Hold counter (32-bit per channel):**
  - Cleared to 0 on the press-commit edge.
  - Increments every cycle while `btn_level`=1, including during RELEASE_PENDING.
  - Saturates at LONG_PRESS_CYCLES, so it never wraps.
- **Long press:** `btn_long` pulses on the edge where the hold counter becomes equal to LONG_PRESS_CYCLES.
  - Because the counter saturates, the pulse cannot repeat within one press.
  - If the release commits first, there is no `btn_long` for that press.
- **Pulse exclusivity:** `btn_press` and `btn_release` are never high together on one channel. `btn_long` can never coincide with `btn_press`. It can coincide with `btn_release` only if the hold counter reaches LONG_PRESS_CYCLES on the same edge the release commits; both pulses are then emitted.
- **Reset values:**
  - `btn_level`, `btn_press`, `btn_release`, `btn_long` = 0.
  - FSMs in RELEASED; all counters 0; synchronizer flops 1.
- **Reset mid-operation:** all pending qualification and hold progress is discarded. If the button is still held when reset deasserts, it is treated as a new press: after full qualification, `btn_press` pulses.

## Timing
- Edge numbering: edge 1 is the first rising edge that samples a changed raw value into flop 1.
  - `s2` reflects the change after edge 2.
  - The FSM takes sample 1 at edge 3.
  - The commit is registered at edge DEBOUNCE_CYCLES+2.
- Outputs change at the commit edge:
  - `btn_level` changes at that edge;
  - the event pulse is high for exactly the one cycle following that edge.
- `btn_long` is registered LONG_PRESS_CYCLES edges after the press-commit edge.
- All outputs are registered; there are no combinational paths from `button` to any output.

## Test plan
Parameters for all scenarios: DEBOUNCE_CYCLES=4, LONG_PRESS_CYCLES=20.
- **Clean press/release:** `button[0]` goes to 0 and is held 40 cycles, then goes to 1.
  - `btn_level[0]` rises at edge 6 with a single `btn_press[0]` pulse.
  - `btn_long[0]` pulses at edge 26.
  - After the release, `btn_level[0]` falls 6 edges later with a single `btn_release[0]` pulse.
- **Bounce rejection:** raw pattern 0,0,0,1,0,0,0,0 (one sample per cycle).
  - No commit after the first three lows.
  - The press commits 4 stable samples after the final 0-run starts; exactly one `btn_press`.
- **Short press:** low for 12 cycles, then high.
  - One `btn_press` and one `btn_release`.
  - `btn_long` stays 0.
- **Release bounce while pressed:** while held, a 2-cycle high glitch occurs after the long press has fired.
  - No `btn_release` is produced.
  - The hold counter is not cleared, and no second `btn_long` occurs.
- **Reset mid-pending:** `rst`=0 while in PRESS_PENDING with the button held.
  - All outputs are 0 immediately.
  - After `rst`=1, `btn_press` pulses exactly 6 edges later.
- **Channel independence:** both buttons are pressed on the same cycle, and `button[1]` is then released early.
  - Simultaneous `btn_press[1:0]`=2'b11.
  - Release events occur only on the correct channel.
